// File: rtl/rtc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rtc_pkg : shared calendar time layout and alarm mask bit positions
// Rev 1.0
// ----------------------------------------------------------------------------
package rtc_pkg;

  localparam int RTC_YEAR_W = 12;
  localparam int TIME_W     = RTC_YEAR_W + 32;

  typedef struct packed {
    logic [RTC_YEAR_W-1:0] year;
    logic [3:0]            month;
    logic [4:0]            day_of_month;
    logic [2:0]            day_of_week;
    logic [1:0]            mode;
    logic [5:0]            hour;
    logic [5:0]            min;
    logic [5:0]            sec;
  } rtc_time_t;

  localparam int MSK_SEC   = 0;
  localparam int MSK_MIN   = 1;
  localparam int MSK_HOUR  = 2;
  localparam int MSK_MODE  = 3;
  localparam int MSK_DOW   = 4;
  localparam int MSK_DOM   = 5;
  localparam int MSK_MONTH = 6;
  localparam int MSK_YEAR  = 7;

  // Bit offsets of each field inside the packed time word (year is the MSB part)
  localparam int OFS_SEC   = 0;
  localparam int OFS_MIN   = 6;
  localparam int OFS_HOUR  = 12;
  localparam int OFS_MODE  = 18;
  localparam int OFS_DOW   = 20;
  localparam int OFS_DOM   = 23;
  localparam int OFS_MONTH = 28;
  localparam int OFS_YEAR  = 32;

endpackage
`default_nettype wire

// File: rtl/rtc_alarm_chan.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rtc_alarm_chan : one alarm compare set with masked match and sticky pending
// Rev 1.0
// ----------------------------------------------------------------------------
module rtc_alarm_chan
  import rtc_pkg::*;
#(
  parameter  int YEAR_W     = RTC_YEAR_W,
  localparam int TIME_WIDTH = YEAR_W + 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [TIME_WIDTH-1:0] cur_time_i,
  input  logic                  we_i,
  input  logic [TIME_WIDTH-1:0] cfg_time_i,
  input  logic [7:0]            cfg_mask_i,
  input  logic                  cfg_en_i,
  input  logic                  ack_i,
  output logic [TIME_WIDTH-1:0] cmp_time_o,
  output logic [7:0]            mask_o,
  output logic                  en_o,
  output logic                  pending_o
);

  logic [TIME_WIDTH-1:0] r_time;
  logic [7:0]            r_mask;
  logic                  r_en;
  logic                  r_match_q;
  logic                  r_pending;
  logic [7:0]            w_field_eq;
  logic                  w_match;

  always_comb begin
    w_field_eq            = '0;
    w_field_eq[MSK_SEC]   = (cur_time_i[OFS_SEC   +: 6] == r_time[OFS_SEC   +: 6]);
    w_field_eq[MSK_MIN]   = (cur_time_i[OFS_MIN   +: 6] == r_time[OFS_MIN   +: 6]);
    w_field_eq[MSK_HOUR]  = (cur_time_i[OFS_HOUR  +: 6] == r_time[OFS_HOUR  +: 6]);
    w_field_eq[MSK_MODE]  = (cur_time_i[OFS_MODE  +: 2] == r_time[OFS_MODE  +: 2]);
    w_field_eq[MSK_DOW]   = (cur_time_i[OFS_DOW   +: 3] == r_time[OFS_DOW   +: 3]);
    w_field_eq[MSK_DOM]   = (cur_time_i[OFS_DOM   +: 5] == r_time[OFS_DOM   +: 5]);
    w_field_eq[MSK_MONTH] = (cur_time_i[OFS_MONTH +: 4] == r_time[OFS_MONTH +: 4]);
    w_field_eq[MSK_YEAR]  = (cur_time_i[TIME_WIDTH-1:OFS_YEAR] == r_time[TIME_WIDTH-1:OFS_YEAR]);
  end

  assign w_match = r_en & (|r_mask) & (&(w_field_eq | ~r_mask));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_time    <= '0;
      r_mask    <= '0;
      r_en      <= 1'b0;
      r_match_q <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      // Forcing the history high on a write stops a freshly programmed
      // current time from firing until the time leaves and re-enters.
      r_match_q <= we_i ? 1'b1 : w_match;
      if (we_i) begin
        r_time <= cfg_time_i;
        r_mask <= cfg_mask_i;
        r_en   <= cfg_en_i;
      end
      if (we_i && !cfg_en_i)
        r_pending <= 1'b0;
      else if (w_match && !r_match_q)
        r_pending <= 1'b1;
      else if (ack_i)
        r_pending <= 1'b0;
    end
  end

  assign cmp_time_o = r_time;
  assign mask_o     = r_mask;
  assign en_o       = r_en;
  assign pending_o  = r_pending;

endmodule
`default_nettype wire

// File: rtl/rtc_alarm_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rtc_alarm_ctrl : multi-channel alarm controller with timestamp capture
// Rev 1.0
// ----------------------------------------------------------------------------
module rtc_alarm_ctrl
  import rtc_pkg::*;
#(
  parameter  int N_ALARMS   = 4,
  parameter  int YEAR_W     = RTC_YEAR_W,
  localparam int IDX_W      = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1,
  localparam int TIME_WIDTH = YEAR_W + 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [TIME_WIDTH-1:0] cur_time_i,
  input  logic                  cfg_we_i,
  input  logic [IDX_W-1:0]      cfg_idx_i,
  input  logic [TIME_WIDTH-1:0] cfg_time_i,
  input  logic [7:0]            cfg_mask_i,
  input  logic                  cfg_en_i,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic [TIME_WIDTH-1:0] rd_time_o,
  output logic [7:0]            rd_mask_o,
  output logic                  rd_en_o,
  input  logic [N_ALARMS-1:0]   ack_i,
  output logic [N_ALARMS-1:0]   pending_o,
  output logic                  irq_o,
  input  logic                  ir_i,
  input  logic                  cap_rd_i,
  output logic [TIME_WIDTH-1:0] cap_time_o,
  output logic                  cap_valid_o,
  output logic                  cap_ovf_o
);

  logic [TIME_WIDTH-1:0] w_cmp_time [N_ALARMS];
  logic [7:0]            w_mask     [N_ALARMS];
  logic [N_ALARMS-1:0]   w_en;
  logic [N_ALARMS-1:0]   w_wr_sel;

  for (genvar k = 0; k < N_ALARMS; k++) begin : g_chan
    assign w_wr_sel[k] = cfg_we_i && (cfg_idx_i == IDX_W'(k));

    rtc_alarm_chan #(
      .YEAR_W (YEAR_W)
    ) u_chan (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .cur_time_i (cur_time_i),
      .we_i       (w_wr_sel[k]),
      .cfg_time_i (cfg_time_i),
      .cfg_mask_i (cfg_mask_i),
      .cfg_en_i   (cfg_en_i),
      .ack_i      (ack_i[k]),
      .cmp_time_o (w_cmp_time[k]),
      .mask_o     (w_mask[k]),
      .en_o       (w_en[k]),
      .pending_o  (pending_o[k])
    );
  end

  // Out-of-range indices (non power-of-two channel counts) read back as zero
  always_comb begin
    rd_time_o = '0;
    rd_mask_o = '0;
    rd_en_o   = 1'b0;
    for (int k = 0; k < N_ALARMS; k++) begin
      if (rd_idx_i == IDX_W'(k)) begin
        rd_time_o = w_cmp_time[k];
        rd_mask_o = w_mask[k];
        rd_en_o   = w_en[k];
      end
    end
  end

  assign irq_o = |pending_o;

  logic                  r_ir_q;
  logic [TIME_WIDTH-1:0] r_cap_time;
  logic                  r_cap_valid;
  logic                  r_cap_ovf;
  logic                  w_ir_rise;

  assign w_ir_rise = ir_i & ~r_ir_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ir_q      <= 1'b0;
      r_cap_time  <= '0;
      r_cap_valid <= 1'b0;
      r_cap_ovf   <= 1'b0;
    end else begin
      r_ir_q <= ir_i;
      if (w_ir_rise) begin
        r_cap_time  <= cur_time_i;
        r_cap_valid <= 1'b1;
        // A same-cycle read consumes the old data, so nothing is lost
        if (cap_rd_i)
          r_cap_ovf <= 1'b0;
        else if (r_cap_valid)
          r_cap_ovf <= 1'b1;
      end else if (cap_rd_i) begin
        r_cap_valid <= 1'b0;
        r_cap_ovf   <= 1'b0;
      end
    end
  end

  assign cap_time_o  = r_cap_time;
  assign cap_valid_o = r_cap_valid;
  assign cap_ovf_o   = r_cap_ovf;

endmodule
`default_nettype wire

// File: tb/tb_rtc_alarm_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rtc_alarm_ctrl : directed and randomized checks against a behavioural model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_rtc_alarm_ctrl;
  import rtc_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  rtc_time_t       cur_time;
  logic            cfg_we;
  logic [IW-1:0]   cfg_idx;
  rtc_time_t       cfg_time;
  logic [7:0]      cfg_mask;
  logic            cfg_en;
  logic [IW-1:0]   rd_idx;
  logic [TIME_W-1:0] rd_time;
  logic [7:0]      rd_mask;
  logic            rd_en;
  logic [N-1:0]    ack;
  logic [N-1:0]    pending;
  logic            irq;
  logic            ir;
  logic            cap_rd;
  logic [TIME_W-1:0] cap_time;
  logic            cap_valid;
  logic            cap_ovf;

  always #5 clk = ~clk;

  rtc_alarm_ctrl #(.N_ALARMS(N), .YEAR_W(RTC_YEAR_W)) dut (
    .clk_i(clk), .rst_i(rst), .cur_time_i(cur_time),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_time_i(cfg_time),
    .cfg_mask_i(cfg_mask), .cfg_en_i(cfg_en),
    .rd_idx_i(rd_idx), .rd_time_o(rd_time), .rd_mask_o(rd_mask), .rd_en_o(rd_en),
    .ack_i(ack), .pending_o(pending), .irq_o(irq),
    .ir_i(ir), .cap_rd_i(cap_rd), .cap_time_o(cap_time),
    .cap_valid_o(cap_valid), .cap_ovf_o(cap_ovf)
  );

  // Behavioural model: alarm table plus capture slot
  rtc_time_t m_time [N];
  bit [7:0]  m_mask [N];
  bit        m_en   [N];
  bit        m_was  [N];
  bit        m_pend [N];
  rtc_time_t m_cap;
  bit        m_valid, m_ovf, m_ir_prev;

  int tests = 0;
  int fails = 0;

  function automatic int fld(rtc_time_t t, int b);
    case (b)
      0: return int'(t.sec);
      1: return int'(t.min);
      2: return int'(t.hour);
      3: return int'(t.mode);
      4: return int'(t.day_of_week);
      5: return int'(t.day_of_month);
      6: return int'(t.month);
      default: return int'(t.year);
    endcase
  endfunction

  function automatic bit alarm_hit(int k);
    if (!m_en[k] || m_mask[k] == 8'd0) return 1'b0;
    for (int b = 0; b < 8; b++)
      if (m_mask[k][b] && fld(cur_time, b) != fld(m_time[k], b)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic rtc_time_t mk(int y, int h, int mi, int s);
    rtc_time_t t;
    t = '0;
    t.year = RTC_YEAR_W'(y); t.month = 4'd3; t.day_of_month = 5'd15;
    t.day_of_week = 3'd5; t.hour = 6'(h); t.min = 6'(mi); t.sec = 6'(s);
    return t;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_time[k] = '0; m_mask[k] = '0; m_en[k] = 0; m_was[k] = 0; m_pend[k] = 0;
    end
    m_cap = '0; m_valid = 0; m_ovf = 0; m_ir_prev = 0;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [N-1:0] pv;
    bit any;
    any = 0;
    for (int k = 0; k < N; k++) begin pv[k] = m_pend[k]; any |= m_pend[k]; end
    chk("pending", 64'(pending), 64'(pv));
    chk("irq", 64'(irq), 64'(any));
    chk("rd_time", 64'(rd_time), 64'(m_time[rd_idx]));
    chk("rd_mask", 64'(rd_mask), 64'(m_mask[rd_idx]));
    chk("rd_en", 64'(rd_en), 64'(m_en[rd_idx]));
    chk("cap_time", 64'(cap_time), 64'(m_cap));
    chk("cap_valid", 64'(cap_valid), 64'(m_valid));
    chk("cap_ovf", 64'(cap_ovf), 64'(m_ovf));
  endtask

  // Advance one clock: model computes the effect of the current inputs,
  // then the DUT outputs are compared shortly after the edge.
  task automatic tick();
    bit n_pend [N];
    bit n_was  [N];
    bit hit, wr, edge_ir;
    for (int k = 0; k < N; k++) begin
      hit = alarm_hit(k);
      wr  = cfg_we && (int'(cfg_idx) == k);
      if (wr && !cfg_en)       n_pend[k] = 0;
      else if (hit && !m_was[k]) n_pend[k] = 1;
      else if (ack[k])         n_pend[k] = 0;
      else                     n_pend[k] = m_pend[k];
      n_was[k] = wr ? 1'b1 : hit;
    end
    edge_ir = ir && !m_ir_prev;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (cfg_we && int'(cfg_idx) == k) begin
        m_time[k] = cfg_time; m_mask[k] = cfg_mask; m_en[k] = cfg_en;
      end
      m_pend[k] = n_pend[k];
      m_was[k]  = n_was[k];
    end
    if (edge_ir) begin
      m_ovf   = cap_rd ? 1'b0 : (m_valid ? 1'b1 : m_ovf);
      m_cap   = cur_time;
      m_valid = 1;
    end else if (cap_rd) begin
      m_valid = 0; m_ovf = 0;
    end
    m_ir_prev = ir;
    if (rst) model_reset();
    check_all();
  endtask

  task automatic cfg(int idx, rtc_time_t t, bit [7:0] m, bit en);
    cfg_we = 1; cfg_idx = IW'(idx); cfg_time = t; cfg_mask = m; cfg_en = en; rd_idx = IW'(idx);
    tick();
    cfg_we = 0;
  endtask

  rtc_time_t pool [4];
  bit        seen;

  initial begin
    rst = 1; cur_time = '0; cfg_we = 0; cfg_idx = '0; cfg_time = '0; cfg_mask = '0;
    cfg_en = 0; rd_idx = '0; ack = '0; ir = 0; cap_rd = 0;
    model_reset();
    @(posedge clk); #1;
    check_all();
    rst = 0;

    // Single channel h:m:s alarm fires once, ack clears, no re-fire
    cfg(0, mk(2024, 12, 30, 0), 8'h07, 1);
    chk("cfg_rd_mask", 64'(rd_mask), 64'h07);
    cur_time = mk(2024, 12, 29, 59); tick();
    cur_time = mk(2024, 12, 30, 0);  tick();
    chk("t1_pend0", 64'(pending[0]), 64'd1);
    chk("t1_irq", 64'(irq), 64'd1);
    for (int i = 0; i < 4; i++) tick();
    ack = 4'b0001; tick(); ack = '0;
    chk("t1_ack", 64'(pending[0]), 64'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("t1_norefire", 64'(pending[0]), 64'd0);

    // Two channels matching together
    cfg(1, mk(0, 0, 0, 10), 8'h01, 1);
    cfg(3, mk(0, 0, 0, 10), 8'h03, 1);
    cur_time = mk(2024, 0, 0, 9);  tick();
    cur_time = mk(2024, 0, 0, 10); tick();
    chk("t2_both", 64'(pending), 64'b1010);
    ack = 4'b0010; tick(); ack = '0;
    chk("t2_ack1", 64'(pending), 64'b1000);
    chk("t2_irq", 64'(irq), 64'd1);
    ack = 4'b1000; tick(); ack = '0;

    // Set beats a same-cycle ack
    cfg(2, mk(0, 0, 0, 20), 8'h01, 1);
    cur_time = mk(2024, 0, 0, 19); tick();
    cur_time = mk(2024, 0, 0, 20); ack = 4'b0100; tick(); ack = '0;
    chk("t3_setwins", 64'(pending[2]), 64'd1);
    ack = 4'b0100; tick(); ack = '0;

    // Programming the displayed time does not fire until it re-enters
    cfg(0, cur_time, 8'h07, 1);
    for (int i = 0; i < 3; i++) tick();
    chk("t4_nofire", 64'(pending[0]), 64'd0);
    cur_time = mk(2024, 0, 0, 21); tick();
    cur_time = mk(2024, 0, 0, 20); tick();
    chk("t4_refire", 64'(pending[0]), 64'd1);

    // Disable clears pending; mask of zero never fires
    cfg(0, cur_time, 8'h07, 0);
    chk("t5_disable", 64'(pending[0]), 64'd0);
    cfg(1, mk(0, 0, 0, 10), 8'h00, 1);
    seen = 0;
    for (int s = 0; s < 60; s++) begin
      cur_time = mk(2024, 0, 0, s); tick();
      seen |= pending[1];
    end
    chk("t5_mask0", 64'(seen), 64'd0);

    // Capture, overflow, read coincident with a new edge
    cur_time = mk(2024, 1, 2, 5); ir = 1; tick(); ir = 0; tick();
    cur_time = mk(2024, 1, 2, 7); ir = 1; tick(); ir = 0; tick();
    chk("t6_sec7", 64'(cap_time[5:0]), 64'd7);
    chk("t6_year", 64'(cap_time[TIME_W-1:32]), 64'd2024);
    chk("t6_valid", 64'(cap_valid), 64'd1);
    chk("t6_ovf", 64'(cap_ovf), 64'd1);
    cur_time = mk(2024, 1, 2, 9); ir = 1; cap_rd = 1; tick(); ir = 0; cap_rd = 0;
    chk("t6_sec9", 64'(cap_time[5:0]), 64'd9);
    chk("t6_valid2", 64'(cap_valid), 64'd1);
    chk("t6_ovf2", 64'(cap_ovf), 64'd0);
    cap_rd = 1; tick(); cap_rd = 0;
    chk("t6_consumed", 64'(cap_valid), 64'd0);

    // Randomized traffic over a small pool of times so matches recur
    for (int i = 0; i < 4; i++) pool[i] = mk(2024, 10, i / 2, (i % 2) * 7);
    for (int i = 0; i < 400; i++) begin
      cur_time = pool[$urandom_range(0, 3)];
      cfg_we   = ($urandom_range(0, 7) == 0);
      cfg_idx  = IW'($urandom_range(0, N - 1));
      cfg_time = pool[$urandom_range(0, 3)];
      cfg_mask = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255)) & 8'h83;
      cfg_en   = ($urandom_range(0, 3) != 0);
      rd_idx   = IW'($urandom_range(0, N - 1));
      ack      = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
      ir       = ($urandom_range(0, 2) == 0);
      cap_rd   = ($urandom_range(0, 4) == 0);
      tick();
    end
    cfg_we = 0; ack = '0; cap_rd = 0;

    // Asynchronous reset mid-cycle, then ir already high at release
    ir = 1; cap_rd = 0;
    #2 rst = 1;
    #1;
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_cap_time", 64'(cap_time), 64'd0);
    chk("rst_valid", 64'(cap_valid), 64'd0);
    chk("rst_ovf", 64'(cap_ovf), 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    model_reset();
    tick();
    rst = 0;
    tick();
    chk("post_rst_cap", 64'(cap_valid), 64'd1);
    chk("post_rst_nofire", 64'(pending), 64'd0);
    ir = 0; tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rtc_alarm_ctrl.md
Name: rtc_alarm_ctrl

Overview:
- Parametrised multi-channel alarm and timestamp-capture controller for the RTC core.
- Holds N_ALARMS programmable alarm compare sets, each with a per-field match mask, an enable and a sticky pending flag; drives one combined interrupt.
- Also captures the current calendar time on the rising edge of an external event into a one-deep capture register with overflow detection.
- Sits between the time-keeping counter (cur_time_i) and the CPU-side register file.

Parameters:
N_ALARMS, 4, number of independent alarm channels (1..16)
YEAR_W, 12, width of the year field
IDX_W, $clog2(N_ALARMS) (min 1), width of alarm index buses (derived, not overridden)

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-high reset
cur_time_i  in  TIME_W  current time, packed rtc_time_t from the time counter
cfg_we_i  in  1  alarm configuration write strobe
cfg_idx_i  in  IDX_W  alarm channel written
cfg_time_i  in  TIME_W  alarm compare time
cfg_mask_i  in  8  field compare enables: bit0 sec, 1 min, 2 hour, 3 mode, 4 day_of_week, 5 day_of_month, 6 month, 7 year
cfg_en_i  in  1  alarm enable
rd_idx_i  in  IDX_W  readback channel select
rd_time_o  out  TIME_W  compare time of channel rd_idx_i
rd_mask_o  out  8  mask of channel rd_idx_i
rd_en_o  out  1  enable of channel rd_idx_i
ack_i  in  N_ALARMS  per-channel pending clear (write-1-to-clear)
pending_o  out  N_ALARMS  sticky pending flags
irq_o  out  1  OR of pending_o
ir_i  in  1  external capture event, synchronous to clk_i
cap_rd_i  in  1  capture register read/consume strobe
cap_time_o  out  TIME_W  captured time
cap_valid_o  out  1  capture register holds unread data
cap_ovf_o  out  1  sticky: a capture overwrote unread data

Behaviour:
- Reset (async, rst_i=1): all compare times, masks, enables, pending, match history, ir_i history, cap_time_o, cap_valid_o and cap_ovf_o clear to 0; irq_o=0.
- Match[k] (combinational) = en[k] AND mask[k]!=0 AND every field with mask bit 1 equals the corresponding cur_time_i field. A mask of 0 never matches.
- Match history match_q[k] is registered every cycle.
- Pending[k] is set on the rising edge of match (match[k] & !match_q[k]). A time held equal for many cycles fires once. Set is visible on pending_o one cycle after the matching cur_time_i cycle.
- ack_i[k]=1 clears pending[k]. If set and ack occur in the same cycle, set wins.
- irq_o = |pending_o, decoded from registers with no extra latency.
- Config write (cfg_we_i=1) updates channel cfg_idx_i at the clock edge; the new values are used from the next cycle.
  - The same edge forces match_q[idx] to 1, so programming the currently displayed time does not fire until the time re-enters the match.
  - Writing cfg_en_i=0 also clears pending[idx]; this takes priority over a same-cycle set on that channel.
- Readback outputs are combinational from the stored registers; a write is visible on readback the cycle after.
- Capture: ir_q is registered.
  - On a rising edge (ir_i & !ir_q): cap_time_o <= cur_time_i and cap_valid_o <= 1.
  - If cap_valid_o was already 1 and cap_rd_i=0 in that cycle, cap_ovf_o <= 1 and the new data overwrites.
  - ir_i high in the first cycle after reset counts as an edge.
- cap_rd_i=1 clears cap_valid_o and cap_ovf_o.
  - If an edge occurs in the same cycle: new data is loaded, valid stays 1, ovf is cleared, and no overflow is flagged.
- Asserting reset mid-operation discards all state immediately; no alarm fires on the first cycle after release unless a match rises.

Decomposition:
- Package rtc_pkg holds:
  - rtc_time_t packed struct {year[YEAR_W], month[4], day_of_month[5], day_of_week[3], mode[2], hour[6], min[6], sec[6]}
  - TIME_W
  - mask bit index constants (MSK_SEC..MSK_YEAR)
- Sub-module rtc_alarm_chan is instantiated N_ALARMS times via generate. It contains the compare registers, the masked comparator, match_q and pending. The top contains the write decode, readback mux, irq OR and the capture logic.

Test Plan:
- Program ch0 to 12:30:00 with mask sec|min|hour and en=1; step cur_time_i from 12:29:59 to 12:30:00 and hold for 5 cycles -> pending_o[0]=1 and irq_o=1 exactly one cycle later; ack_i[0] pulse -> 0; no re-fire while held.
- Two channels match in the same cycle (ch1 mask sec=10, ch3 mask sec=10, min=0) at 00:00:10 -> pending_o=4'b1010; ack ch1 -> pending 4'b1000 and irq_o stays 1.
- Hold ack_i[2]=1 in the cycle ch2's match rises -> pending_o[2]=1 (set wins).
- Program ch0 to the exact current time, enable and hold -> no pending; advance one second and return to the same time -> fires.
- Write en=0 to a pending channel -> pending cleared next cycle. Write mask=0 with en=1 -> never fires over a full minute sweep.
- ir_i edges at year 2024 sec 5 then sec 7 with no read -> cap_time_o sec=7, cap_valid_o=1, cap_ovf_o=1. cap_rd_i coincident with a third edge at sec 9 -> sec=9, valid=1, ovf=0. Assert rst_i mid-test -> all outputs 0 asynchronously.
